fft_result_streamer: RTL and testbench

FFT_RESULT_STREAMER -- requirements
Module: fft_result_streamer

---
 rtl/fft_result_streamer_if.sv | 19 +
 rtl/fft_result_streamer.sv | 141 ++++++++++++++
 tb/tb_fft_result_streamer.sv | 532 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_result_streamer_if.sv
// UART transmit handshake between the FFT result streamer and a byte-wide UART.
// Member names are written from the streamer's point of view.
interface fft_result_streamer_if;
  logic [7:0] o_tx_byte;
  logic       o_tx_start;
  logic       i_tx_done;

  modport master (
    output o_tx_byte,
    output o_tx_start,
    input  i_tx_done
  );

  modport slave (
    input  o_tx_byte,
    input  o_tx_start,
    output i_tx_done
  );
endinterface

// File: rtl/fft_result_streamer.sv
// Captures one frame of complex FFT results and streams it byte by byte to a UART,
// optionally preceded by a header byte. Captures arriving mid-frame are dropped and flagged.
module fft_result_streamer #(
  parameter int         WORD_SIZE   = 16,
  parameter int         N_POINTS    = 2,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BYTE = 8'hA5,
  parameter int         MSB_FIRST   = 0
) (
  input  logic                            i_clk,
  input  logic                            w_rst,
  input  logic                            i_capture,
  input  logic [N_POINTS*2*WORD_SIZE-1:0] i_data,
  fft_result_streamer_if.master           tx,
  output logic                            o_busy,
  output logic                            o_frame_done,
  output logic                            o_overrun
);

  localparam int BPW     = WORD_SIZE / 8;
  localparam int HDR     = (HEADER_EN != 0) ? 1 : 0;
  localparam int N_WORDS = 2 * N_POINTS;
  localparam int NBYTES  = HDR + N_WORDS * BPW;
  localparam int DATA_W  = N_WORDS * WORD_SIZE;
  localparam int IDX_W   = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_buf;
  logic [IDX_W-1:0]  r_idx;
  logic              r_overrun;

  logic              w_accept;
  logic              w_advance;
  logic              w_last;
  logic              w_tx_start;
  logic              w_busy;
  logic              w_frame_done;
  logic [7:0]        w_sel_byte;
  logic [7:0]        w_frame_bytes [NBYTES];

  assign w_accept  = (r_state == ST_IDLE) && i_capture;
  assign w_advance = (r_state == ST_WAIT) && tx.i_tx_done;
  assign w_last    = (r_idx == LAST_IDX);

  // Frame layout as a flat byte array: optional header, then re/im words in point order.
  generate
    if (HDR == 1) begin : g_hdr
      assign w_frame_bytes[0] = HEADER_BYTE;
    end
    for (genvar gw = 0; gw < N_WORDS; gw++) begin : g_word
      for (genvar gb = 0; gb < BPW; gb++) begin : g_byte
        localparam int LANE = (MSB_FIRST != 0) ? (BPW - 1 - gb) : gb;
        assign w_frame_bytes[HDR + gw*BPW + gb] = r_buf[gw*WORD_SIZE + LANE*8 +: 8];
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge i_clk or posedge w_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    if (w_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves the
    // signal unassigned and infers a latch.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (i_capture) w_next_state = ST_SEND;
      ST_SEND: w_next_state = ST_WAIT;
      ST_WAIT: if (tx.i_tx_done) w_next_state = w_last ? ST_DONE : ST_SEND;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Frame buffer, byte index and sticky overrun flag.
  always_ff @(posedge i_clk or posedge w_rst) begin
    // NOTE: the frame buffer is reset too, so the byte mux never presents X
    // and a reset mid-frame leaves no stale data behind.
    if (w_rst) begin
      r_buf     <= '0;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf <= i_data;
        r_idx <= '0;
      end else if (w_advance && !w_last) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (i_capture && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Byte currently addressed by the index; only buffer and index feed it.
  always_comb begin
    w_sel_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_idx == IDX_W'(i)) w_sel_byte = w_frame_bytes[i];
    end
  end

  // Output decode from the current state.
  always_comb begin
    w_tx_start   = 1'b0;
    w_busy       = 1'b1;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: w_busy       = 1'b0;
      ST_SEND: w_tx_start   = 1'b1;
      ST_DONE: w_frame_done = 1'b1;
      default: ;
    endcase
  end

  // The byte is forced to zero in IDLE so reset drives every output low.
  assign tx.o_tx_byte  = w_busy ? w_sel_byte : 8'h00;
  assign tx.o_tx_start = w_tx_start;
  assign o_busy        = w_busy;
  assign o_frame_done  = w_frame_done;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_fft_result_streamer.sv
// Bench for fft_result_streamer: a default instance and an MSB-first headerless instance,
// each served by a UART model, with frames checked against a byte-order reference model.
`timescale 1ns/1ps
module tb_fft_result_streamer;

  localparam int WORD_SIZE = 16;
  localparam int N_POINTS  = 2;
  localparam int DATA_W    = N_POINTS * 2 * WORD_SIZE;
  localparam int NB_A      = 9;
  localparam int NB_B      = 8;
  localparam logic [DATA_W-1:0] SPEC_DATA = {16'hFF00, 16'h0300, 16'h0100, 16'h0200};

  typedef logic [7:0] byte_q_t [$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cap_a = 1'b0;
  logic              cap_b = 1'b0;
  logic [DATA_W-1:0] data_a = '0;
  logic [DATA_W-1:0] data_b = '0;
  logic              busy_a, fd_a, ovr_a;
  logic              busy_b, fd_b, ovr_b;
  logic              model_done_a = 1'b0;
  logic              model_done_b = 1'b0;
  logic              manual_done_a = 1'b0;
  bit                uart_en_a = 1'b1;
  bit                uart_rand_lat = 1'b0;
  int                lat_a, lat_b;

  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc = 0;
  byte_q_t got_a, got_b;
  int      starts_a = 0, starts_b = 0;
  int      fds_a = 0, fds_b = 0;
  int      last_done_cyc_a = 0, fd_cyc_a = 0;

  fft_result_streamer_if tx_a ();
  fft_result_streamer_if tx_b ();

  assign tx_a.i_tx_done = model_done_a | manual_done_a;
  assign tx_b.i_tx_done = model_done_b;

  fft_result_streamer dut_a (
    .i_clk        (clk),
    .w_rst        (rst),
    .i_capture    (cap_a),
    .i_data       (data_a),
    .tx           (tx_a),
    .o_busy       (busy_a),
    .o_frame_done (fd_a),
    .o_overrun    (ovr_a)
  );

  fft_result_streamer #(.HEADER_EN(0), .MSB_FIRST(1)) dut_b (
    .i_clk        (clk),
    .w_rst        (rst),
    .i_capture    (cap_b),
    .i_data       (data_b),
    .tx           (tx_b),
    .o_busy       (busy_b),
    .o_frame_done (fd_b),
    .o_overrun    (ovr_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the UART side mid-cycle.
  always @(negedge clk) begin
    if (tx_a.o_tx_start === 1'b1) begin
      got_a.push_back(tx_a.o_tx_byte);
      starts_a <= starts_a + 1;
    end
    if (tx_a.i_tx_done === 1'b1) last_done_cyc_a <= cyc;
    if (fd_a === 1'b1) begin
      fds_a    <= fds_a + 1;
      fd_cyc_a <= cyc;
    end
    if (tx_b.o_tx_start === 1'b1) begin
      got_b.push_back(tx_b.o_tx_byte);
      starts_b <= starts_b + 1;
    end
    if (fd_b === 1'b1) fds_b <= fds_b + 1;
  end

  // UART models: i_tx_done pulses a fixed (or random) number of cycles after each start.
  initial begin
    forever begin
      if (uart_en_a && tx_a.o_tx_start === 1'b1) begin
        lat_a = uart_rand_lat ? int'($urandom_range(1, 6)) : 10;
        for (int k = 0; k < lat_a && rst !== 1'b1; k++) begin @(posedge clk); #1; end
        if (rst !== 1'b1) begin
          model_done_a = 1'b1;
          @(posedge clk); #1;
          model_done_a = 1'b0;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  initial begin
    forever begin
      if (tx_b.o_tx_start === 1'b1) begin
        lat_b = uart_rand_lat ? int'($urandom_range(1, 6)) : 10;
        for (int k = 0; k < lat_b && rst !== 1'b1; k++) begin @(posedge clk); #1; end
        if (rst !== 1'b1) begin
          model_done_b = 1'b1;
          @(posedge clk); #1;
          model_done_b = 1'b0;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: header (optional), then p0.re, p0.im, p1.re, ... each split into bytes.
  function automatic byte_q_t expected_frame(input logic [DATA_W-1:0] d, input bit hdr,
                                             input bit msb);
    byte_q_t q;
    logic [WORD_SIZE-1:0] word;
    int sh;
    if (hdr) q.push_back(8'hA5);
    for (int p = 0; p < N_POINTS; p++) begin
      for (int part = 0; part < 2; part++) begin
        word = d[(2*p + part)*WORD_SIZE +: WORD_SIZE];
        for (int b = 0; b < WORD_SIZE/8; b++) begin
          sh = msb ? (WORD_SIZE/8 - 1 - b) * 8 : b * 8;
          q.push_back(8'(word >> sh));
        end
      end
    end
    return q;
  endfunction

  function automatic string q_str(input byte_q_t q, input int from);
    string s = "";
    for (int i = from; i < q.size(); i++) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom} | {(DATA_W/8){8'h01}};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_starts(input bit use_b, input int target, input int budget, output bit ok);
    int k = 0;
    while ((use_b ? starts_b : starts_a) < target && k < budget) begin step(1); k++; end
    ok = ((use_b ? starts_b : starts_a) >= target);
  endtask

  task automatic wait_fd(input bit use_b, input int target, input int budget, output bit ok);
    int k = 0;
    while ((use_b ? fds_b : fds_a) < target && k < budget) begin step(1); k++; end
    ok = ((use_b ? fds_b : fds_a) >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    n_checks++;
    if ({tx_a.o_tx_start, busy_a, fd_a, ovr_a} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctrl_a: start/busy/fd/ovr=%b expected 0000",
               {tx_a.o_tx_start, busy_a, fd_a, ovr_a});
    end
    n_checks++;
    if (tx_a.o_tx_byte !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_byte_a: got %02h expected 00", tx_a.o_tx_byte);
    end
    n_checks++;
    if ({tx_b.o_tx_start, busy_b, fd_b, ovr_b, tx_b.o_tx_byte} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_b: outputs=%h expected 000",
               {tx_b.o_tx_start, busy_b, fd_b, ovr_b, tx_b.o_tx_byte});
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_default_frame();
    byte_q_t exp;
    int base, sbase, fbase;
    bit ok;
    exp   = expected_frame(SPEC_DATA, 1'b1, 1'b0);
    base  = got_a.size();
    sbase = starts_a;
    fbase = fds_a;
    data_a = SPEC_DATA;
    cap_a  = 1'b1;
    step(1);
    cap_a  = 1'b0;
    n_checks++;
    if (tx_a.o_tx_start !== 1'b1 || tx_a.o_tx_byte !== 8'hA5 || busy_a !== 1'b1) begin
      n_errors++;
      $display("FAIL default_latency: start=%b byte=%02h busy=%b expected 1 A5 1",
               tx_a.o_tx_start, tx_a.o_tx_byte, busy_a);
    end
    data_a = rand_data();
    wait_fd(1'b0, fbase + 1, 400, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL default_timeout: no frame_done"); end
    step(3);
    n_checks++;
    if (q_str(got_a, base) != q_str(exp, 0)) begin
      n_errors++;
      $display("FAIL default_bytes: got %s expected %s", q_str(got_a, base), q_str(exp, 0));
    end
    n_checks++;
    if (starts_a - sbase != NB_A || fds_a - fbase != 1) begin
      n_errors++;
      $display("FAIL default_counts: starts=%0d fds=%0d expected %0d 1",
               starts_a - sbase, fds_a - fbase, NB_A);
    end
    n_checks++;
    if (fd_cyc_a != last_done_cyc_a + 1) begin
      n_errors++;
      $display("FAIL default_fd_timing: fd cycle %0d expected %0d", fd_cyc_a, last_done_cyc_a + 1);
    end
    n_checks++;
    if (ovr_a !== 1'b0 || busy_a !== 1'b0) begin
      n_errors++;
      $display("FAIL default_idle: ovr=%b busy=%b expected 0 0", ovr_a, busy_a);
    end
  endtask

  task automatic test_msb_first();
    byte_q_t exp;
    int base, sbase, fbase;
    bit ok;
    exp   = expected_frame(SPEC_DATA, 1'b0, 1'b1);
    base  = got_b.size();
    sbase = starts_b;
    fbase = fds_b;
    data_b = SPEC_DATA;
    cap_b  = 1'b1;
    step(1);
    cap_b  = 1'b0;
    n_checks++;
    if (tx_b.o_tx_start !== 1'b1 || tx_b.o_tx_byte !== exp[0]) begin
      n_errors++;
      $display("FAIL msb_first_byte: start=%b byte=%02h expected 1 %02h",
               tx_b.o_tx_start, tx_b.o_tx_byte, exp[0]);
    end
    data_b = rand_data();
    wait_fd(1'b1, fbase + 1, 400, ok);
    step(3);
    n_checks++;
    if (!ok || q_str(got_b, base) != q_str(exp, 0) || starts_b - sbase != NB_B) begin
      n_errors++;
      $display("FAIL msb_first_frame: got %s (%0d starts) expected %s (%0d starts)",
               q_str(got_b, base), starts_b - sbase, q_str(exp, 0), NB_B);
    end
  endtask

  task automatic test_random_frames();
    byte_q_t exp_a, exp_b;
    logic [DATA_W-1:0] da, db;
    int base_a, base_b, fa, fb;
    bit ok_a, ok_b;
    uart_rand_lat = 1'b1;
    for (int it = 0; it < 4; it++) begin
      da = rand_data();
      db = rand_data();
      exp_a = expected_frame(da, 1'b1, 1'b0);
      exp_b = expected_frame(db, 1'b0, 1'b1);
      base_a = got_a.size();
      base_b = got_b.size();
      fa = fds_a;
      fb = fds_b;
      data_a = da;
      data_b = db;
      cap_a = 1'b1;
      cap_b = 1'b1;
      step(1);
      cap_a = 1'b0;
      cap_b = 1'b0;
      data_a = ~da;
      data_b = ~db;
      wait_fd(1'b0, fa + 1, 200, ok_a);
      wait_fd(1'b1, fb + 1, 200, ok_b);
      step(2);
      n_checks++;
      if (!ok_a || q_str(got_a, base_a) != q_str(exp_a, 0)) begin
        n_errors++;
        $display("FAIL random_a[%0d]: got %s expected %s", it, q_str(got_a, base_a), q_str(exp_a, 0));
      end
      n_checks++;
      if (!ok_b || q_str(got_b, base_b) != q_str(exp_b, 0)) begin
        n_errors++;
        $display("FAIL random_b[%0d]: got %s expected %s", it, q_str(got_b, base_b), q_str(exp_b, 0));
      end
    end
    uart_rand_lat = 1'b0;
  endtask

  task automatic test_overrun();
    byte_q_t exp1, exp3;
    logic [DATA_W-1:0] d1, d3;
    int base, sbase, fbase;
    bit ok;
    d1 = rand_data();
    d3 = rand_data();
    exp1 = expected_frame(d1, 1'b1, 1'b0);
    exp3 = expected_frame(d3, 1'b1, 1'b0);
    base = got_a.size();
    sbase = starts_a;
    fbase = fds_a;
    data_a = d1;
    cap_a = 1'b1;
    step(1);
    cap_a = 1'b0;
    wait_starts(1'b0, sbase + 3, 100, ok);
    step(2);
    data_a = rand_data();
    cap_a = 1'b1;
    step(1);
    cap_a = 1'b0;
    n_checks++;
    if (!ok || ovr_a !== 1'b1) begin
      n_errors++;
      $display("FAIL overrun_set: ovr=%b reached_byte3=%b expected 1 1", ovr_a, ok);
    end
    wait_fd(1'b0, fbase + 1, 300, ok);
    step(2);
    n_checks++;
    if (!ok || q_str(got_a, base) != q_str(exp1, 0) || starts_a - sbase != NB_A) begin
      n_errors++;
      $display("FAIL overrun_frame: got %s expected %s", q_str(got_a, base), q_str(exp1, 0));
    end
    n_checks++;
    if (ovr_a !== 1'b1) begin
      n_errors++;
      $display("FAIL overrun_sticky_after_done: ovr=%b expected 1", ovr_a);
    end
    base = got_a.size();
    fbase = fds_a;
    data_a = d3;
    cap_a = 1'b1;
    step(1);
    cap_a = 1'b0;
    wait_fd(1'b0, fbase + 1, 300, ok);
    step(2);
    n_checks++;
    if (!ok || ovr_a !== 1'b1 || q_str(got_a, base) != q_str(exp3, 0)) begin
      n_errors++;
      $display("FAIL overrun_next_capture: ovr=%b got %s expected 1 %s",
               ovr_a, q_str(got_a, base), q_str(exp3, 0));
    end
  endtask

  task automatic test_reset_midframe();
    byte_q_t exp;
    logic [DATA_W-1:0] d2;
    int base, sbase, fbase;
    bit ok;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    sbase = starts_a;
    data_a = rand_data();
    cap_a = 1'b1;
    step(1);
    cap_a = 1'b0;
    wait_starts(1'b0, sbase + 4, 100, ok);
    step(2);
    n_checks++;
    if (!ok || busy_a !== 1'b1 || tx_a.o_tx_byte === 8'h00) begin
      n_errors++;
      $display("FAIL midreset_pre: busy=%b byte=%02h expected busy 1 nonzero byte",
               busy_a, tx_a.o_tx_byte);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({tx_a.o_tx_start, busy_a, fd_a, ovr_a, tx_a.o_tx_byte} !== 12'h000) begin
      n_errors++;
      $display("FAIL midreset_async: outputs=%h expected 000",
               {tx_a.o_tx_start, busy_a, fd_a, ovr_a, tx_a.o_tx_byte});
    end
    @(posedge clk); #2;
    d2 = rand_data();
    exp = expected_frame(d2, 1'b1, 1'b0);
    base = got_a.size();
    fbase = fds_a;
    rst = 1'b0;
    data_a = d2;
    cap_a = 1'b1;
    step(1);
    cap_a = 1'b0;
    n_checks++;
    if (tx_a.o_tx_start !== 1'b1 || tx_a.o_tx_byte !== 8'hA5) begin
      n_errors++;
      $display("FAIL midreset_restart: start=%b byte=%02h expected 1 A5",
               tx_a.o_tx_start, tx_a.o_tx_byte);
    end
    wait_fd(1'b0, fbase + 1, 300, ok);
    step(2);
    n_checks++;
    if (!ok || q_str(got_a, base) != q_str(exp, 0)) begin
      n_errors++;
      $display("FAIL midreset_frame: got %s expected %s", q_str(got_a, base), q_str(exp, 0));
    end
  endtask

  task automatic test_stall();
    byte_q_t exp;
    logic [DATA_W-1:0] d;
    logic [7:0] held;
    int base, sbase, fbase, bad;
    bit ok;
    d = rand_data();
    exp = expected_frame(d, 1'b1, 1'b0);
    base = got_a.size();
    sbase = starts_a;
    fbase = fds_a;
    data_a = d;
    cap_a = 1'b1;
    step(1);
    cap_a = 1'b0;
    wait_starts(1'b0, sbase + 3, 100, ok);
    uart_en_a = 1'b0;
    wait_starts(1'b0, sbase + 4, 100, ok);
    step(1);
    held = tx_a.o_tx_byte;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      if (busy_a !== 1'b1 || tx_a.o_tx_start !== 1'b0 || fd_a !== 1'b0 ||
          tx_a.o_tx_byte !== held) bad++;
      step(1);
    end
    n_checks++;
    if (!ok || bad != 0 || held !== exp[3]) begin
      n_errors++;
      $display("FAIL stall_hold: bad_cycles=%0d byte=%02h expected 0 %02h",
               bad, held, exp[3]);
    end
    uart_en_a = 1'b1;
    manual_done_a = 1'b1;
    step(1);
    manual_done_a = 1'b0;
    wait_fd(1'b0, fbase + 1, 300, ok);
    step(2);
    n_checks++;
    if (!ok || q_str(got_a, base) != q_str(exp, 0)) begin
      n_errors++;
      $display("FAIL stall_resume: got %s expected %s", q_str(got_a, base), q_str(exp, 0));
    end
  endtask

  task automatic test_spurious();
    byte_q_t exp;
    logic [DATA_W-1:0] d;
    int base, sbase, fbase, k;
    bit ok;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    sbase = starts_a;
    manual_done_a = 1'b1;
    step(3);
    manual_done_a = 1'b0;
    step(2);
    n_checks++;
    if (starts_a != sbase || busy_a !== 1'b0) begin
      n_errors++;
      $display("FAIL spurious_idle_done: starts=%0d busy=%b expected 0 0", starts_a - sbase, busy_a);
    end
    d = rand_data();
    exp = expected_frame(d, 1'b1, 1'b0);
    base = got_a.size();
    fbase = fds_a;
    data_a = d;
    cap_a = 1'b1;
    step(1);
    cap_a = 1'b0;
    k = 0;
    while (!(starts_a - sbase == NB_A && tx_a.i_tx_done === 1'b1) && k < 300) begin
      step(1);
      k++;
    end
    ok = (k < 300);
    data_a = rand_data();
    cap_a = 1'b1;
    step(1);
    cap_a = 1'b0;
    step(20);
    n_checks++;
    if (!ok || ovr_a !== 1'b1) begin
      n_errors++;
      $display("FAIL spurious_final_capture_ovr: ovr=%b found_final=%b expected 1 1", ovr_a, ok);
    end
    n_checks++;
    if (starts_a - sbase != NB_A || fds_a - fbase != 1 || busy_a !== 1'b0 ||
        q_str(got_a, base) != q_str(exp, 0)) begin
      n_errors++;
      $display("FAIL spurious_no_extra: starts=%0d fds=%0d busy=%b got %s expected %0d 1 0 %s",
               starts_a - sbase, fds_a - fbase, busy_a, q_str(got_a, base), NB_A, q_str(exp, 0));
    end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_msb_first();
    test_random_frames();
    test_overrun();
    test_reset_midframe();
    test_stall();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
